// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage access unit.
package mem_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } mem_mode_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SPLIT = 1'b1
  } state_t;

  // Right-aligned byte mask of the access size; zero for unsupported modes.
  function automatic logic [3:0] size_mask(input logic [2:0] mode);
    case (mode)
      MODE_B, MODE_BU: size_mask = 4'b0001;
      MODE_H, MODE_HU: size_mask = 4'b0011;
      MODE_W:          size_mask = 4'b1111;
      default:         size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load assembly: joins the two halves of a split load,
// shifts the addressed bytes down and applies sign/zero extension.
module load_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [1:0]            off,
  input  logic [2:0]            mode,
  output logic [DATA_WIDTH-1:0] result
);

  logic                    split;
  logic [2*DATA_WIDTH-1:0] window;
  logic [DATA_WIDTH-1:0]   val;

  // An access is split when its byte mask spills past lane 3.
  assign split  = (({4'b0000, size_mask(mode)} << off) > 8'd15);
  assign window = split ? {hi, lo} : {{DATA_WIDTH{1'b0}}, hi};
  assign val    = DATA_WIDTH'(window >> {off, 3'b000});

  always_comb begin
    result = '0;
    case (mode)
      MODE_B:  result = {{(DATA_WIDTH-8){val[7]}}, val[7:0]};
      MODE_H:  result = {{(DATA_WIDTH-16){val[15]}}, val[15:0]};
      MODE_W:  result = val;
      MODE_BU: result = {{(DATA_WIDTH-8){1'b0}}, val[7:0]};
      MODE_HU: result = {{(DATA_WIDTH-16){1'b0}}, val[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: byte enables, lane-shifted store data, load
// extension, and a two-state FSM that splits misaligned accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WORDS = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            modeBUM,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WORDS-1:0] mem_addr,
  output logic [NUM_LANES-1:0]  mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                  state, state_n;
  logic [1:0]              off;
  logic [ADDR_WORDS-1:0]   word_a;
  logic [3:0]              mask;
  logic [7:0]              be_full;
  logic [2*DATA_WIDTH-1:0] wd_full;
  logic                    is_store, is_load, load_ok, store_ok, req_ok, split;
  logic                    ld_n, lo_cap;
  logic                    ld_q;
  logic [1:0]              off_q;
  logic [2:0]              mode_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [DATA_WIDTH-1:0]   ld_result;
  logic                    unused_ok;

  assign unused_ok = RegWriteM;

  // Access decode; the 8-lane views cover both words of a split access.
  assign off      = ALUResultM[1:0];
  assign word_a   = ALUResultM[DATA_WIDTH-1:2];
  assign mask     = size_mask(modeBUM);
  assign be_full  = {4'b0000, mask} << off;
  assign wd_full  = {{DATA_WIDTH{1'b0}}, WriteDataM} << {off, 3'b000};
  assign is_store = MemWriteM;
  assign is_load  = (ResultSrcM == RESULT_SRC_LOAD) && !MemWriteM;
  assign load_ok  = |mask;
  assign store_ok = load_ok && !modeBUM[2];
  assign req_ok   = is_store ? store_ok : (is_load && load_ok);
  assign split    = |be_full[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ld_q   <= 1'b0;
      lo_q   <= '0;
      off_q  <= '0;
      mode_q <= '0;
    end else begin
      state <= state_n;
      ld_q  <= ld_n;
      if (lo_cap) lo_q <= mem_rdata;
      if (ld_n) begin
        off_q  <= off;
        mode_q <= modeBUM;
      end
    end
  end

  always_comb begin
    state_n   = state;
    StallM    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = word_a;
    mem_be    = '0;
    mem_wdata = wd_full[DATA_WIDTH-1:0];
    ld_n      = 1'b0;
    lo_cap    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_ok) begin
          mem_req = 1'b1;
          mem_we  = is_store;
          mem_be  = be_full[3:0];
          if (split) begin
            StallM  = 1'b1;
            state_n = S_SPLIT;
          end else begin
            ld_n = is_load;
          end
        end
      end
      S_SPLIT: begin
        mem_req   = req_ok;
        mem_we    = is_store;
        mem_addr  = word_a + ADDR_WORDS'(1);
        mem_be    = be_full[7:4];
        mem_wdata = wd_full[2*DATA_WIDTH-1:DATA_WIDTH];
        ld_n      = is_load && req_ok;
        lo_cap    = is_load && req_ok;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Reset suppresses any request, including the second half of a split.
    if (rst) begin
      mem_req = 1'b0;
      StallM  = 1'b0;
    end
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .lo     (lo_q),
    .hi     (mem_rdata),
    .off    (off_q),
    .mode   (mode_q),
    .result (ld_result)
  );

  assign ReadDataW = ld_q ? ld_result : '0;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit that consumes the EX/MEM pipeline register outputs and drives the synchronous data memory. It generates byte enables and lane-shifted store data, sign- or zero-extends loads, and returns load data aligned with the writeback stage. Misaligned halfword and word accesses are split into two word accesses by a small FSM. The unit raises a one-cycle stall while the split is in progress.

## Interface
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- ADDR_WORDS, 30, width of the word address presented to memory, equal to DATA_WIDTH-2.
- clk  in  1  clock; all state updates occur on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- RegWriteM  in  1  pass-through only; not used internally.
- ResultSrcM  in  2  2'b01 marks a load.
- MemWriteM  in  1  store request.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- modeBUM  in  3  access mode, funct3 encoding.
- StallM  out  1  freeze request for PC, IF/ID, ID/EX and EX/MEM.
- ReadDataW  out  32  extended load data, valid in the cycle after a load completes.
- mem_req  out  1  memory access this cycle.
- mem_we  out  1  write when mem_req is high.
- mem_addr  out  30  word address.
- mem_be  out  4  byte enables; bit i covers bits [8i+7:8i].
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  read data for the word whose request was sampled at the previous edge.

## Operation
- Access decode:
  - Load when ResultSrcM==2'b01 and MemWriteM==0.
  - Store when MemWriteM==1.
  - Both asserted: treated as a store.
- Modes:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Stores use only 000, 001 and 010.
  - Modes 011, 110 and 111 cause no request, no stall, and ReadDataW=0 in the following cycle.
- Offset: off = ALUResultM[1:0]; size n = 1, 2 or 4 bytes.
- Aligned access (off+n<=4): single request.
  - mem_addr = ALUResultM[31:2].
  - mem_be has n bits set starting at bit off.
  - mem_wdata = WriteDataM << 8*off.
- Misaligned access (off+n>4): a halfword at off=3, or a word at off 1 to 3.
  - First request: mem_addr=A, be = bytes off..3.
  - Second request: mem_addr=A+1 (mod 2^30, so 0x3FFFFFFF wraps to 0), be = the remaining low bytes.
  - mem_wdata in each request carries the matching bytes of WriteDataM.
- FSM states: IDLE, SPLIT.
  - IDLE with a misaligned access: issue the first request, StallM=1, next state SPLIT.
  - SPLIT: issue the second request, StallM=0, capture mem_rdata lanes from the first access into lo_q (loads only), next state IDLE.
  - Any other IDLE access: StallM=0, remain in IDLE.
- Load completion:
  - A registered flag ld_q is set for the cycle after the final load request.
  - Registered copies of off, mode and lo_q record the access in flight.
  - ReadDataW = extend(assemble(lo_q, mem_rdata)) when ld_q is set, else 0.
  - B/H sign-extend bit 7/15; BU/HU zero-extend.
- Upstream must hold the EX/MEM inputs stable while StallM=1.

## Timing
- Aligned load: request in cycle N, ReadDataW valid in cycle N+1, no stall.
- Aligned store: memory is written at the end of cycle N.
- Misaligned access: requests in N and N+1, StallM high in N only, load data valid in N+2.
- Back-to-back loads: ld_q and the in-flight registers update every cycle. The result of load N is on ReadDataW in N+1 while load N+1 issues.
- Reset behaviour:
  - While rst=1, mem_req=0 combinationally, so no stray write occurs mid-SPLIT.
  - At the reset edge: state becomes IDLE; ld_q and lo_q are cleared.
  - Following cycle: ReadDataW=0 and StallM=0.
- Reset asserted during SPLIT: the second half is dropped. Recovery is owned by the pipeline flush.

## Structure
- Package mem_pkg holds:
  - typedef enum logic [2:0] mem_mode_t (MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU).
  - typedef enum logic state_t (S_IDLE, S_SPLIT).
  - The constant RESULT_SRC_LOAD = 2'b01.
- Sub-module load_align is purely combinational. It takes lo bytes, hi word, off and mode, and produces the 32-bit extended result. The top level holds the FSM, the registers and the store lane logic.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100: mem_be=1111 and mem_addr=0x40. ReadDataW=0xDEADBEEF in the next cycle, StallM never high.
- SB 0x000000F0 @0x103, then LB and LBU @0x103: mem_be=1000 and mem_wdata=0xF0000000. LB returns 0xFFFFFFF0, LBU returns 0x000000F0.
- SW 0x11223344 @0x102:
  - Cycle 1: StallM=1, mem_addr=0x40, be=1100, wdata bytes 0x3344 in lanes 2 and 3.
  - Cycle 2: mem_addr=0x41, be=0011.
  - LW @0x102 afterwards returns 0x11223344 two cycles after issue.
- LH @0xFFFFFFFF with mem[0x3FFFFFFF][31:24]=0x80 and mem[0][7:0]=0x7F: second address wraps to 0, ReadDataW=0x00007F80.
- Reset asserted in the SPLIT cycle of a misaligned SW: mem_req=0 that cycle. Word 0x41 is unchanged; the next cycle has StallM=0 and ReadDataW=0.
- Mode 3'b111 with ResultSrcM=01: no request, no stall, ReadDataW=0.
